wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin bus arbiter for the shared Wishbone interconnect. Decides which of MASTERS_NUM
//  masters owns the bus and holds ownership until that master drops cyc. Optional watchdog
//  aborts stalled cycles. The interconnect muxes master signals using grant_idx_o/gnt_valid_o
//  and ORs tmo_err_o into i2m_err_o.
// PARAMETERS
//  MASTERS_NUM     2    number of requesters, >=2
//  TIMEOUT_CYCLES  256  stalled-cycle limit before abort (watchdog only), >=2
//  IDX_W (local)   $clog2(MASTERS_NUM); CNT_W (local) $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk_i        in   1            clock, all logic on rising edge
//  rst_ni       in   1            synchronous reset, active-low
//  m_cyc_i      in   MASTERS_NUM  per-master cyc (bus request)
//  m_stb_i      in   MASTERS_NUM  per-master stb
//  bus_ack_i    in   1            ack returned by the currently selected slave
//  bus_err_i    in   1            err returned by the currently selected slave
//  grant_o      out  MASTERS_NUM  one-hot owner, all-zero when no owner
//  grant_idx_o  out  IDX_W        binary owner index, holds last owner when idle
//  gnt_valid_o  out  1            bus owned and routed; intercon gates i2s_cyc/stb with it
//  tmo_err_o    out  MASTERS_NUM  one-cycle timeout error pulse to the owner
// BEHAVIOUR
//  - Reset (rst_ni=0 at edge): state=IDLE, grant_o=0, grant_idx_o=0, gnt_valid_o=0, tmo_err_o=0,
//    counter=0, last-owner pointer=MASTERS_NUM-1 (master 0 wins first). Reset mid-cycle
//    drops ownership immediately, no error pulse.
//  - IDLE: if |m_cyc_i, pick first requester scanning from pointer+1 upward with wrap,
//    skipping non-requesters; register grant -> OWNED. Latency: grant visible 1 cycle after cyc seen.
//  - OWNED: gnt_valid_o=1. If m_cyc_i[grant_idx_o]==0 -> IDLE, pointer<=grant_idx_o,
//    grant_o<=0, gnt_valid_o<=0. Always one dead IDLE cycle between owners.
//  - Requests from non-owners never preempt; a requester that drops cyc before grant loses nothing.
//  - Single requester repeatedly: re-granted after each dead cycle (pointer wraps past it).
//  - Watchdog counter (OWNED): increments when m_stb_i[owner]&~bus_ack_i&~bus_err_i,
//    clears on ack/err or stb low; saturating, never wraps.
//    Reaching TIMEOUT_CYCLES: tmo_err_o[owner]=1 exactly one cycle, gnt_valid_o<=0, -> ABORT.
//    ack/err in the same cycle as the limit wins: counter clears, no error.
//  - ABORT: gnt_valid_o=0, grant_o/grant_idx_o held, tmo_err_o=0; on owner cyc low -> IDLE,
//    pointer advances as in OWNED.
// CONFIGURATION
//  WB_ARB_WATCHDOG_EN defined: counter, ABORT state, tmo_err_o active as above.
//  Not defined: no counter logic; tmo_err_o tied to 0; ABORT unreachable; TIMEOUT_CYCLES unused;
//  a stalled owner holds the bus indefinitely.
// STRUCTURE
//  Package wb_arb_pkg: state_t enum {ARB_IDLE, ARB_OWNED, ARB_ABORT}; helper function
//  onehot(idx) for grant_o.
//  Sub-module wb_rr_pick: combinational, inputs req[MASTERS_NUM], ptr[IDX_W]; outputs
//  found, idx[IDX_W] (first set req after ptr, wrapping). Arbiter FSM/counter in top.
// TESTING
//  1 Reset held, m_cyc_i=2'b11; release rst_ni -> next cycle grant_o=2'b01, grant_idx_o=0, gnt_valid_o=1.
//  2 Both request continuously; M0 drops cyc at cycle 4 -> cycle 5 grant_o=0, cycle 6 grant_o=2'b10.
//  3 MASTERS_NUM=4, pointer=0, only m_cyc_i[3]=1 -> grant_idx_o=3 one cycle later (M1,M2 skipped).
//  4 Watchdog on, TIMEOUT_CYCLES=8, M0 stb=1, no ack -> tmo_err_o=4'b0001 on 8th stalled cycle
//    only, gnt_valid_o=0 after; M0 drops cyc -> IDLE, M1 granted next if requesting.
//  5 Watchdog on, ack on the 8th stalled cycle -> no tmo_err_o, counter 0, ownership kept.
//  6 rst_ni=0 while OWNED with counter=5 -> next cycle all outputs at reset values;
//    watchdog off build: 1000 stalled cycles -> tmo_err_o stays 0, grant held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam int unsigned ARB_MAX_M = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_ABORT = 2'd2
  } state_t;

  // One-hot vector for a master index; callers size-cast to their width.
  function automatic logic [ARB_MAX_M-1:0] onehot(input int unsigned idx);
    return ARB_MAX_M'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module wb_rr_pick #(
  parameter  int unsigned MASTERS_NUM = 2,
  localparam int unsigned IDX_W       = $clog2(MASTERS_NUM)
) (
  input  logic [MASTERS_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   found_c,
  output logic [IDX_W-1:0]       idx_c
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan downward so the lowest index in each half is the one left standing.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = int'(MASTERS_NUM) - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        if ($unsigned(j) > 32'(ptr_i)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(j);
        end
      end
    end
    found_c = hi_found | lo_found;
    idx_c   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus arbiter with ownership held until the owner drops cyc.
// Optional stalled-cycle watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int unsigned MASTERS_NUM    = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned IDX_W          = $clog2(MASTERS_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [MASTERS_NUM-1:0] m_cyc_i,
  input  logic [MASTERS_NUM-1:0] m_stb_i,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i,
  output logic [MASTERS_NUM-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   gnt_valid_o,
  output logic [MASTERS_NUM-1:0] tmo_err_o
);

  state_t                 state_q, state_d;
  logic [MASTERS_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   found_c;
  logic [IDX_W-1:0]       idx_c;

  wb_rr_pick #(.MASTERS_NUM(MASTERS_NUM)) u_pick (
    .req_i   (m_cyc_i),
    .ptr_i   (ptr_q),
    .found_c (found_c),
    .idx_c   (idx_c)
  );

`ifdef WB_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MASTERS_NUM-1:0] tmo_err_q, tmo_err_d;
  logic                   stall_c;

  assign stall_c = m_stb_i[grant_idx_q] & ~bus_ack_i & ~bus_err_i;
`else
  logic unused_wd_c;
  assign unused_wd_c = ^{m_stb_i, bus_ack_i, bus_err_i, TIMEOUT_CYCLES};
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
`ifdef WB_ARB_WATCHDOG_EN
    cnt_d       = cnt_q;
    tmo_err_d   = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
`ifdef WB_ARB_WATCHDOG_EN
        cnt_d = '0;
`endif
        if (found_c) begin
          grant_d     = MASTERS_NUM'(onehot(32'(idx_c)));
          grant_idx_d = idx_c;
          gnt_valid_d = 1'b1;
          state_d     = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!m_cyc_i[grant_idx_q]) begin
          ptr_d       = grant_idx_q;
          grant_d     = '0;
          gnt_valid_d = 1'b0;
          state_d     = ARB_IDLE;
        end
`ifdef WB_ARB_WATCHDOG_EN
        // An ack/err on the limit cycle is not a stall, so it wins over the abort.
        else if (stall_c) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d       = CNT_W'(TIMEOUT_CYCLES);
            tmo_err_d   = grant_q;
            gnt_valid_d = 1'b0;
            state_d     = ARB_ABORT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
`endif
      end
      ARB_ABORT: begin
        if (!m_cyc_i[grant_idx_q]) begin
          ptr_d   = grant_idx_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= IDX_W'(MASTERS_NUM - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      tmo_err_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign tmo_err_o = tmo_err_q;
`else
  assign tmo_err_o = '0;
`endif

  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: a 2-master table run plus 4-master watchdog sequences.
module tb_wb_rr_arbiter;

`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-master instance
  logic       a_rst, a_ack, a_err;
  logic [1:0] a_cyc, a_stb, a_grant, a_tmo;
  logic [0:0] a_idx;
  logic       a_gv;

  // 4-master instance, short watchdog
  logic       b_rst, b_ack, b_err;
  logic [3:0] b_cyc, b_stb, b_grant, b_tmo;
  logic [1:0] b_idx;
  logic       b_gv;

  wb_rr_arbiter #(.MASTERS_NUM(2), .TIMEOUT_CYCLES(256)) dut_a (
    .clk_i(clk), .rst_ni(a_rst), .m_cyc_i(a_cyc), .m_stb_i(a_stb),
    .bus_ack_i(a_ack), .bus_err_i(a_err), .grant_o(a_grant),
    .grant_idx_o(a_idx), .gnt_valid_o(a_gv), .tmo_err_o(a_tmo)
  );

  wb_rr_arbiter #(.MASTERS_NUM(4), .TIMEOUT_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_ni(b_rst), .m_cyc_i(b_cyc), .m_stb_i(b_stb),
    .bus_ack_i(b_ack), .bus_err_i(b_err), .grant_o(b_grant),
    .grant_idx_o(b_idx), .gnt_valid_o(b_gv), .tmo_err_o(b_tmo)
  );

  typedef struct {
    int         id;
    bit         is_b;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       gv;
    logic [3:0] tmo;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] grant;
    logic       idx;
    logic       gv;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input exp_t e);
    logic [3:0] g, t;
    logic [1:0] ix;
    logic       v;
    if (e.is_b) begin
      g = b_grant; ix = b_idx; v = b_gv; t = b_tmo;
    end else begin
      g = {2'b00, a_grant}; ix = {1'b0, a_idx}; v = a_gv; t = {2'b00, a_tmo};
    end
    n_vec++;
    if (g !== e.grant || ix !== e.idx || v !== e.gv || t !== e.tmo) begin
      n_bad++;
      $display("FAIL vec %0d (%s): grant=%b idx=%0d gv=%b tmo=%b, required grant=%b idx=%0d gv=%b tmo=%b",
               e.id, e.is_b ? "m4" : "m2", g, ix, v, t, e.grant, e.idx, e.gv, e.tmo);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic b_step(input int id, input logic rst, input logic [3:0] cyc,
                        input logic [3:0] stb, input logic ack,
                        input logic [3:0] g, input logic [1:0] ix,
                        input logic v, input logic [3:0] t);
    exp_t e;
    b_rst = rst; b_cyc = cyc; b_stb = stb; b_ack = ack;
    e.id = id; e.is_b = 1'b1; e.grant = g; e.idx = ix; e.gv = v; e.tmo = t;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    exp_t e;
    bit   held_bad;

    a_rst = 1'b0; a_cyc = '0; a_stb = '0; a_ack = 1'b0; a_err = 1'b0;
    b_rst = 1'b0; b_cyc = '0; b_stb = '0; b_ack = 1'b0; b_err = 1'b0;

    //          rst   cyc    grant  idx   gv
    tbl[0]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      a_rst = tbl[i].rst;
      a_cyc = tbl[i].cyc;
      e.id = i; e.is_b = 1'b0;
      e.grant = {2'b00, tbl[i].grant}; e.idx = {1'b0, tbl[i].idx};
      e.gv = tbl[i].gv; e.tmo = 4'b0000;
      sb.push_back(e);
      tick();
    end
    a_cyc = '0;

    // 4 masters: skip non-requesters, then stall the owner into the watchdog.
    b_step(100, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    b_step(101, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    b_step(102, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    b_step(103, 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000);
    b_step(104, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 4'b0000);
    b_step(105, 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    for (int k = 1; k <= 7; k++)
      b_step(110 + k, 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    b_step(118, 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0001, 2'd0, !WD, WD ? 4'b0001 : 4'b0000);
    b_step(119, 1'b1, 4'b0011, 4'b0001, 1'b0, 4'b0001, 2'd0, !WD, 4'b0000);
    b_step(120, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    b_step(121, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000);

    // Ack on the limit cycle wins; counter restarts from zero.
    for (int k = 1; k <= 7; k++)
      b_step(130 + k, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000);
    b_step(138, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0000);
    for (int k = 1; k <= 5; k++)
      b_step(140 + k, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000);

    // Reset mid-ownership with a partial count; count must not carry over.
    b_step(150, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    b_step(151, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    for (int k = 1; k <= 7; k++)
      b_step(151 + k, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    b_step(159, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, !WD, WD ? 4'b0001 : 4'b0000);

`ifndef WB_ARB_WATCHDOG_EN
    // Without the watchdog a stalled owner keeps the bus indefinitely.
    held_bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (b_tmo !== 4'b0000 || b_gv !== 1'b1 || b_grant !== 4'b0001) held_bad = 1'b1;
    end
    n_vec++;
    if (held_bad) begin
      n_bad++;
      $display("FAIL long_stall: grant=%b gv=%b tmo=%b, required grant held at 0001, gv=1, tmo=0000 for 1000 cycles",
               b_grant, b_gv, b_tmo);
    end
`else
    held_bad = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
